// File: rtl/iact_spad_pe.sv
`default_nettype none
// ============================================================================
//  Module      : iact_spad_pe
//  Description : PE-local input-activation scratchpad. Captures an
//                ACT_SIZE x ACT_SIZE plane from the iact router, then streams
//                KERNEL_SIZE x KERNEL_SIZE windows row-major to the MAC over
//                a valid/ready interface. Optional zero-skipping of window
//                beats is enabled by defining IACT_ZERO_SKIP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module iact_spad_pe #(
    parameter int DATA_BITWIDTH      = 16,
    parameter int ADDR_BITWIDTH_SPAD = 9,
    parameter int ACT_SIZE           = 5,
    parameter int KERNEL_SIZE        = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_BITWIDTH-1:0] w_data_spad,
    input  logic                     load_en_spad,
    input  logic                     clear_spad,
    output logic                     loaded,
    output logic                     overflow,
    input  logic                     start_win,
    input  logic [7:0]               win_row,
    input  logic [7:0]               win_col,
    output logic                     win_err,
    output logic [DATA_BITWIDTH-1:0] out_data,
    output logic [7:0]               out_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     win_done
);

    localparam int                            c_N         = ACT_SIZE * ACT_SIZE;
    localparam int                            c_DEPTH     = 2 ** ADDR_BITWIDTH_SPAD;
    localparam logic [ADDR_BITWIDTH_SPAD-1:0] c_LAST_ADDR = ADDR_BITWIDTH_SPAD'(c_N - 1);
    localparam logic [ADDR_BITWIDTH_SPAD-1:0] c_ACT       = ADDR_BITWIDTH_SPAD'(ACT_SIZE);
    localparam logic [ADDR_BITWIDTH_SPAD-1:0] c_K_LAST    = ADDR_BITWIDTH_SPAD'(KERNEL_SIZE - 1);
    localparam logic [7:0]                    c_MAX_ORG   = 8'(ACT_SIZE - KERNEL_SIZE);
    localparam logic [7:0]                    c_LAST_POS  = 8'(KERNEL_SIZE * KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_FULL   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t                          r_state;
    logic [DATA_BITWIDTH-1:0]        r_mem [0:c_DEPTH-1];
    logic [ADDR_BITWIDTH_SPAD-1:0]   r_wptr;
    logic                            r_loaded;
    logic                            r_overflow;
    logic                            r_win_err;
    logic                            r_out_valid;
    logic [DATA_BITWIDTH-1:0]        r_out_data;
    logic [7:0]                      r_out_idx;
    logic [ADDR_BITWIDTH_SPAD-1:0]   r_org_row;
    logic [ADDR_BITWIDTH_SPAD-1:0]   r_org_col;
    logic [ADDR_BITWIDTH_SPAD-1:0]   r_kr;
    logic [ADDR_BITWIDTH_SPAD-1:0]   r_kc;
    logic [7:0]                      r_pos;
    logic                            r_issuing;
    logic                            r_last;

    logic                            w_advance;
    logic                            w_mem_we;
    logic                            w_win_ok;
    logic                            w_beat_valid;
    logic [ADDR_BITWIDTH_SPAD-1:0]   w_rd_addr;
    logic [DATA_BITWIDTH-1:0]        w_rd_data;

    assign w_advance = !r_out_valid || out_ready;
    assign w_mem_we  = !reset && !clear_spad && (r_state == S_LOAD) && load_en_spad;
    assign w_win_ok  = (win_row <= c_MAX_ORG) && (win_col <= c_MAX_ORG);
    assign w_rd_addr = (r_org_row + r_kr) * c_ACT + (r_org_col + r_kc);
    assign w_rd_data = r_mem[w_rd_addr];

`ifdef IACT_ZERO_SKIP_EN
    // Zero activations contribute nothing to the MAC; drop them at the source.
    assign w_beat_valid = (w_rd_data != '0);
`else
    assign w_beat_valid = 1'b1;
`endif

    // Plane storage: written only while loading, so stray writes never corrupt it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wptr] <= w_data_spad;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_wptr      <= '0;
            r_loaded    <= 1'b0;
            r_overflow  <= 1'b0;
            r_win_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_org_row   <= '0;
            r_org_col   <= '0;
            r_kr        <= '0;
            r_kc        <= '0;
            r_pos       <= '0;
            r_issuing   <= 1'b0;
            r_last      <= 1'b0;
        end else if (clear_spad) begin
            r_state     <= S_LOAD;
            r_wptr      <= '0;
            r_loaded    <= 1'b0;
            r_overflow  <= 1'b0;
            r_win_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_issuing   <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_win_err <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (load_en_spad) begin
                        r_wptr <= r_wptr + 1'b1;
                        if (r_wptr == c_LAST_ADDR) begin
                            r_state  <= S_FULL;
                            r_loaded <= 1'b1;
                        end
                    end
                end

                S_FULL: begin
                    if (load_en_spad) begin
                        r_overflow <= 1'b1;
                    end
                    if (start_win) begin
                        if (w_win_ok) begin
                            r_org_row <= ADDR_BITWIDTH_SPAD'(win_row);
                            r_org_col <= ADDR_BITWIDTH_SPAD'(win_col);
                            r_kr      <= '0;
                            r_kc      <= '0;
                            r_pos     <= '0;
                            r_issuing <= 1'b1;
                            r_state   <= S_STREAM;
                        end else begin
                            r_win_err <= 1'b1;
                        end
                    end
                end

                S_STREAM: begin
                    if (load_en_spad) begin
                        r_overflow <= 1'b1;
                    end
                    // The read register doubles as the output stage; it only
                    // moves when the current beat is empty or being taken.
                    if (w_advance) begin
                        if (r_issuing) begin
                            r_out_data  <= w_rd_data;
                            r_out_idx   <= r_pos;
                            r_out_valid <= w_beat_valid;
                            r_pos       <= r_pos + 8'd1;
                            if (r_kc == c_K_LAST) begin
                                r_kc <= '0;
                                r_kr <= r_kr + 1'b1;
                            end else begin
                                r_kc <= r_kc + 1'b1;
                            end
                            if (r_pos == c_LAST_POS) begin
                                r_issuing <= 1'b0;
                                r_last    <= 1'b1;
                            end
                        end else begin
                            r_out_valid <= 1'b0;
                        end
                        if (r_last) begin
                            r_last  <= 1'b0;
                            r_state <= S_FULL;
                        end
                    end
                end

                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    // Done coincides with the output stage holding the final window position
    // and that stage being consumed (or empty, when the tail was skipped).
    assign win_done  = !reset && !clear_spad && (r_state == S_STREAM) && r_last && w_advance;
    assign loaded    = r_loaded;
    assign overflow  = r_overflow;
    assign win_err   = r_win_err;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;

endmodule
`default_nettype wire

// File: tb/tb_iact_spad_pe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iact_spad_pe
//  Description : Directed self-checking bench for iact_spad_pe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iact_spad_pe;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] w_data_spad;
    logic        load_en_spad;
    logic        clear_spad;
    logic        loaded;
    logic        overflow;
    logic        start_win;
    logic [7:0]  win_row;
    logic [7:0]  win_col;
    logic        win_err;
    logic [15:0] out_data;
    logic [7:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        win_done;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_d[$];
    int exp_i[$];
    int got_d[$];
    int got_i[$];

    iact_spad_pe #(
        .DATA_BITWIDTH      (16),
        .ADDR_BITWIDTH_SPAD (9),
        .ACT_SIZE           (5),
        .KERNEL_SIZE        (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .w_data_spad  (w_data_spad),
        .load_en_spad (load_en_spad),
        .clear_spad   (clear_spad),
        .loaded       (loaded),
        .overflow     (overflow),
        .start_win    (start_win),
        .win_row      (win_row),
        .win_col      (win_col),
        .win_err      (win_err),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .win_done     (win_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads base+0 .. base+24; addresses listed in zero_a get 0 instead.
    task automatic load_plane(input int base, input int zero_a, input int zero_b);
        load_en_spad = 1'b1;
        for (int a = 0; a < 25; a++) begin
            w_data_spad = ((a == zero_a) || (a == zero_b)) ? 16'd0 : 16'(base + a);
            step();
        end
        load_en_spad = 1'b0;
        #1;
        chk("loaded_after_plane", loaded, 1);
    endtask

    task automatic run_win(input int row, input int col, input bit toggle, input int first_exp);
        int   cyc;
        int   first;
        bit   done;
        bit   stalled;
        int   hd;
        int   hi;
        got_d.delete();
        got_i.delete();
        win_row   = 8'(row);
        win_col   = 8'(col);
        start_win = 1'b1;
        out_ready = 1'b1;
        step();
        start_win = 1'b0;
        cyc = 1; first = -1; done = 1'b0; stalled = 1'b0; hd = 0; hi = 0;
        while (!done && cyc < 80) begin
            out_ready = toggle ? ((cyc % 3) == 2) : 1'b1;
            #1;
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hd);
                chk("hold_idx", out_idx, hi);
            end
            if (out_valid && first < 0) first = cyc;
            if (out_valid && out_ready) begin
                got_d.push_back(int'(out_data));
                got_i.push_back(int'(out_idx));
            end
            stalled = out_valid && !out_ready;
            hd = int'(out_data);
            hi = int'(out_idx);
            if (win_done) begin
                done = 1'b1;
                chk("done_idx", out_idx, 8);
                chk("done_with_accept", out_valid && out_ready, 1);
            end
            step();
            cyc++;
        end
        out_ready = 1'b1;
        chk("win_done_seen", done, 1);
        chk("first_valid_cycle", first, first_exp);
        chk("beat_count", got_d.size(), exp_d.size());
        for (int k = 0; k < exp_d.size(); k++) begin
            chk("beat_data", (k < got_d.size()) ? got_d[k] : -1, exp_d[k]);
            chk("beat_idx", (k < got_i.size()) ? got_i[k] : -1, exp_i[k]);
        end
        #1;
        chk("valid_after_done", out_valid, 0);
    endtask

    initial begin
        reset = 1'b1; w_data_spad = '0; load_en_spad = 1'b0; clear_spad = 1'b0;
        start_win = 1'b0; win_row = '0; win_col = '0; out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_loaded", loaded, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_win_err", win_err, 0);
        chk("rst_win_done", win_done, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);

        // Plane 1..25; start_win during LOAD is ignored without error.
        load_en_spad = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            w_data_spad = 16'(i);
            start_win   = (i == 3);
            if (i == 25) begin
                #1;
                chk("loaded_before_last", loaded, 0);
            end
            step();
            start_win = 1'b0;
            if (i == 4) chk("no_err_in_load", win_err, 0);
        end
        load_en_spad = 1'b0;
        #1;
        chk("loaded_after_25", loaded, 1);
        chk("overflow_after_25", overflow, 0);

        // 26th write is dropped and sets sticky overflow.
        load_en_spad = 1'b1;
        w_data_spad  = 16'd99;
        step();
        load_en_spad = 1'b0;
        #1;
        chk("overflow_set", overflow, 1);
        step();
        chk("overflow_sticky", overflow, 1);

        exp_d = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
        exp_i = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        run_win(0, 0, 1'b0, 2);
        chk("overflow_still", overflow, 1);

        exp_d = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
        run_win(2, 2, 1'b1, 2);

        // Out-of-range origin.
        win_row = 8'd3; win_col = 8'd0; start_win = 1'b1;
        step();
        start_win = 1'b0;
        #1;
        chk("range_row_err", win_err, 1);
        chk("range_row_valid", out_valid, 0);
        step();
        chk("range_err_pulse", win_err, 0);
        chk("range_no_valid", out_valid, 0);
        win_row = 8'd0; win_col = 8'd3; start_win = 1'b1;
        step();
        start_win = 1'b0;
        #1;
        chk("range_col_err", win_err, 1);
        step();
        chk("range_col_pulse", win_err, 0);
        chk("range_keeps_loaded", loaded, 1);

        // Still FULL: a legal window streams normally.
        exp_d = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
        run_win(1, 1, 1'b0, 2);

        // Clear in mid-stream; the simultaneous write must be dropped.
        win_row = 8'd0; win_col = 8'd0; start_win = 1'b1; out_ready = 1'b0;
        step();
        start_win = 1'b0;
        step();
        chk("pre_clear_valid", out_valid, 1);
        clear_spad = 1'b1; load_en_spad = 1'b1; w_data_spad = 16'd77;
        step();
        clear_spad = 1'b0; load_en_spad = 1'b0; out_ready = 1'b1;
        #1;
        chk("clear_valid", out_valid, 0);
        chk("clear_loaded", loaded, 0);
        chk("clear_overflow", overflow, 0);
        chk("clear_done", win_done, 0);
        load_plane(101, -1, -1);
        exp_d = '{101, 102, 103, 106, 107, 108, 111, 112, 113};
        run_win(0, 0, 1'b0, 2);

        // Reset while streaming window (1,1) under stall.
        win_row = 8'd1; win_col = 8'd1; start_win = 1'b1; out_ready = 1'b0;
        step();
        start_win = 1'b0;
        step();
        chk("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0; out_ready = 1'b1;
        #1;
        chk("mrst_loaded", loaded, 0);
        chk("mrst_overflow", overflow, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_out_idx", out_idx, 0);
        chk("mrst_win_err", win_err, 0);
        chk("mrst_win_done", win_done, 0);

        // Plane with zeros at addresses 6 and 12 (value a+1 elsewhere).
        load_plane(1, 6, 12);
`ifdef IACT_ZERO_SKIP_EN
        exp_d = '{8, 9, 12, 14, 17, 18, 19};
        exp_i = '{1, 2, 3, 5, 6, 7, 8};
        run_win(1, 1, 1'b0, 3);
`else
        exp_d = '{0, 8, 9, 12, 0, 14, 17, 18, 19};
        exp_i = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        run_win(1, 1, 1'b0, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
